// File: rtl/cdb_arbiter.sv
// Common-data-bus producer: per-source result FIFOs with round-robin pick, one registered broadcast per cycle.
// One cycle minimum from input transfer to broadcast; src_ready drops only when a source's FIFO is full.
module cdb_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int TAG_W     = 5,
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*XLEN-1:0]   src_value,
    input  logic [NUM_SRC-1:0]        src_take_branch,
    input  logic [NUM_SRC*XLEN-1:0]   src_target_pc,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [XLEN-1:0]           cdb_value,
    output logic                      cdb_take_branch,
    output logic [XLEN-1:0]           cdb_target_pc
);

    localparam int ENT_W = 1 + 2 * XLEN + TAG_W;
    localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW    = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(BUF_DEPTH - 1);

    // Entry layout: {take_branch, target_pc, tag, value}
    logic [ENT_W-1:0] r_buf   [NUM_SRC][BUF_DEPTH];
    logic [PW-1:0]    r_rptr  [NUM_SRC];
    logic [PW-1:0]    r_wptr  [NUM_SRC];
    logic [CW-1:0]    r_count [NUM_SRC];
    logic [SW-1:0]    r_rr_ptr;

    logic             r_cdb_valid;
    logic [TAG_W-1:0] r_cdb_tag;
    logic [XLEN-1:0]  r_cdb_value;
    logic             r_cdb_take_branch;
    logic [XLEN-1:0]  r_cdb_target_pc;

    logic [ENT_W-1:0]   w_in [NUM_SRC];
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_gnt_vld;
    logic [SW-1:0]      w_gnt;
    logic [ENT_W-1:0]   w_head;
    logic               w_flush;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SW'(s);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_in[i]      = {src_take_branch[i], src_target_pc[i*XLEN +: XLEN],
                               src_tag[i*TAG_W +: TAG_W], src_value[i*XLEN +: XLEN]};
        assign src_ready[i] = !reset && (r_count[i] < DEPTH_C);
        assign w_push[i]    = src_valid[i] && src_ready[i];
        assign w_pop[i]     = w_gnt_vld && (w_gnt == SW'(i));
    end

    // Scan downwards so the last hit written is the nearest non-empty source at or after rr_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (r_count[wrap_add(r_rr_ptr, k)] != '0) begin
                w_gnt_vld = 1'b1;
                w_gnt     = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_head  = r_buf[w_gnt][r_rptr[w_gnt]];
    assign w_flush = w_gnt_vld && w_head[ENT_W-1];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) r_buf[i][r_wptr[i]] <= w_in[i];
        end
    end

    // A flush empties every FIFO, which also drops anything accepted on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rptr[i]  <= '0;
                r_wptr[i]  <= '0;
                r_count[i] <= '0;
            end
            r_rr_ptr          <= '0;
            r_cdb_valid       <= 1'b0;
            r_cdb_tag         <= '0;
            r_cdb_value       <= '0;
            r_cdb_take_branch <= 1'b0;
            r_cdb_target_pc   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_flush) begin
                    r_rptr[i]  <= '0;
                    r_wptr[i]  <= '0;
                    r_count[i] <= '0;
                end else begin
                    if (w_push[i]) r_wptr[i] <= next_ptr(r_wptr[i]);
                    if (w_pop[i])  r_rptr[i] <= next_ptr(r_rptr[i]);
                    if (w_push[i] && !w_pop[i])
                        r_count[i] <= r_count[i] + CW'(1);
                    else if (!w_push[i] && w_pop[i])
                        r_count[i] <= r_count[i] - CW'(1);
                end
            end
            r_cdb_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                {r_cdb_take_branch, r_cdb_target_pc, r_cdb_tag, r_cdb_value} <= w_head;
            end
            if (w_flush)
                r_rr_ptr <= '0;
            else if (w_gnt_vld)
                r_rr_ptr <= wrap_add(w_gnt, 1);
        end
    end

    assign cdb_valid       = r_cdb_valid;
    assign cdb_tag         = r_cdb_tag;
    assign cdb_value       = r_cdb_value;
    assign cdb_take_branch = r_cdb_take_branch;
    assign cdb_target_pc   = r_cdb_target_pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-level reference model compared every cycle plus literal checkpoints.
module tb_cdb_arbiter;

    typedef struct packed {
        logic        tb;
        logic [31:0] pc;
        logic [4:0]  tag;
        logic [31:0] value;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_tag;
    logic [95:0] src_value;
    logic [2:0]  src_take_branch;
    logic [95:0] src_target_pc;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_take_branch;
    logic [31:0] cdb_target_pc;

    cdb_arbiter #(.NUM_SRC(3), .TAG_W(5), .XLEN(32), .BUF_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_value(src_value),
        .src_take_branch(src_take_branch), .src_target_pc(src_target_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_take_branch(cdb_take_branch), .cdb_target_pc(cdb_target_pc)
    );

    always #5 clock = ~clock;

    ent_t       pq [3][$];   // results each source still wants to hand over
    ent_t       mq [3][$];   // model of what each source has buffered
    int         rr = 0;
    logic       m_valid = 1'b0;
    ent_t       m_out = '0;
    logic [4:0] blog [$];    // tags the DUT actually broadcast
    int         vectors;
    int         miscompares;

    // Reference: pick oldest from first non-empty queue at/after rr, then append accepted inputs.
    always @(posedge clock) begin : model
        ent_t e;
        int   g;
        int   idx;
        bit   flush;
        bit   acc [3];
        if (reset) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr      = 0;
            m_valid = 1'b0;
            m_out   = '0;
        end else begin
            for (int i = 0; i < 3; i++) acc[i] = src_valid[i] && (mq[i].size() < 2);
            g = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (rr + k) % 3;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            flush = 1'b0;
            if (g >= 0) begin
                m_out   = mq[g].pop_front();
                m_valid = 1'b1;
                rr      = (g + 1) % 3;
                flush   = m_out.tb;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    e.tb    = src_take_branch[i];
                    e.pc    = src_target_pc[i*32 +: 32];
                    e.tag   = src_tag[i*5 +: 5];
                    e.value = src_value[i*32 +: 32];
                    mq[i].push_back(e);
                    void'(pq[i].pop_front());
                end
            end
            if (flush) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
                rr = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_item(input int s, input logic [4:0] t, input logic [31:0] v,
                             input logic b, input logic [31:0] pc);
        ent_t e;
        e.tb = b; e.pc = pc; e.tag = t; e.value = v;
        pq[s].push_back(e);
    endtask

    // One cycle: compare at the falling edge, then present each source's next pending result.
    task automatic step();
        logic [2:0] er;
        @(negedge clock);
        for (int i = 0; i < 3; i++) er[i] = !reset && (mq[i].size() < 2);
        chk("cdb_valid", 128'(cdb_valid), 128'(m_valid));
        chk("src_ready", 128'(src_ready), 128'(er));
        chk("cdb_payload", 128'({cdb_take_branch, cdb_target_pc, cdb_tag, cdb_value}), 128'(m_out));
        if (cdb_valid === 1'b1) blog.push_back(cdb_tag);
        for (int i = 0; i < 3; i++) begin
            if (pq[i].size() > 0) begin
                src_valid[i]             = 1'b1;
                src_take_branch[i]       = pq[i][0].tb;
                src_target_pc[i*32 +: 32] = pq[i][0].pc;
                src_tag[i*5 +: 5]        = pq[i][0].tag;
                src_value[i*32 +: 32]    = pq[i][0].value;
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin : main
        int b;
        int exp4 [6];
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        src_valid = '0; src_tag = '0; src_value = '0;
        src_take_branch = '0; src_target_pc = '0;

        step();
        step();
        chk("rst_valid", 128'(cdb_valid), 128'(0));
        chk("rst_ready", 128'(src_ready), 128'(0));
        chk("rst_payload", 128'({cdb_take_branch, cdb_target_pc, cdb_tag, cdb_value}), 128'(0));
        reset = 1'b0;

        // Single result: accepted at edge 1, on the bus after edge 2 only
        push_item(0, 5'd5, 32'h1234, 1'b0, 32'h0);
        step();
        step();
        chk("t1_not_early", 128'(cdb_valid), 128'(0));
        step();
        chk("t1_valid", 128'(cdb_valid), 128'(1));
        chk("t1_tag", 128'(cdb_tag), 128'(5));
        chk("t1_value", 128'(cdb_value), 128'(32'h1234));
        step();
        chk("t1_one_cycle", 128'(cdb_valid), 128'(0));
        b = blog.size();
        push_item(2, 5'd0, 32'hffff_ffff, 1'b0, 32'h0);
        repeat (4) step();
        chk("tag0_count", 128'(blog.size()), 128'(b + 1));
        chk("tag0_tag", 128'(blog[b]), 128'(0));

        // Simultaneous pushes from all three sources
        do_reset();
        b = blog.size();
        push_item(0, 5'd1, 32'h100, 1'b0, 32'h0);
        push_item(1, 5'd2, 32'h200, 1'b0, 32'h0);
        push_item(2, 5'd3, 32'h300, 1'b0, 32'h0);
        step(); step(); step();
        chk("t2_first", 128'({cdb_valid, cdb_tag}), 128'({1'b1, 5'd1}));
        step();
        chk("t2_second", 128'({cdb_valid, cdb_tag}), 128'({1'b1, 5'd2}));
        step();
        chk("t2_third", 128'({cdb_valid, cdb_tag}), 128'({1'b1, 5'd3}));
        step();
        chk("t2_idle", 128'(cdb_valid), 128'(0));
        // Pointer back at 0: source 0 must win over source 2
        push_item(2, 5'd10, 32'h1000, 1'b0, 32'h0);
        push_item(0, 5'd11, 32'h1100, 1'b0, 32'h0);
        repeat (5) step();
        chk("t2_rr_first", 128'(blog[b+3]), 128'(11));
        chk("t2_rr_second", 128'(blog[b+4]), 128'(10));

        // Fairness: src0 streams, src2 injects tag 9 once
        do_reset();
        b = blog.size();
        for (int t = 11; t <= 16; t++) push_item(0, 5'(t), 32'(t * 3), 1'b0, 32'h0);
        push_item(2, 5'd9, 32'h999, 1'b0, 32'h0);
        repeat (12) step();
        chk("t3_b0", 128'(blog[b]), 128'(11));
        chk("t3_b1", 128'(blog[b+1]), 128'(9));
        chk("t3_b2", 128'(blog[b+2]), 128'(12));
        chk("t3_count", 128'(blog.size()), 128'(b + 7));
        chk("t3_last", 128'(blog[b+6]), 128'(16));

        // Backpressure on src1 and FIFO pointer wrap
        do_reset();
        b = blog.size();
        for (int t = 0; t < 3; t++) begin
            push_item(0, 5'(20 + t), 32'(20 + t), 1'b0, 32'h0);
            push_item(1, 5'(4 + t), 32'(4 + t), 1'b0, 32'h0);
        end
        step(); step(); step();
        chk("t4_ready_low", 128'(src_ready[1]), 128'(0));
        step();
        chk("t4_ready_back", 128'(src_ready[1]), 128'(1));
        repeat (6) step();
        exp4 = '{20, 4, 21, 5, 22, 6};
        for (int k = 0; k < 6; k++) chk("t4_order", 128'(blog[b+k]), 128'(exp4[k]));

        // Flush squashes buffered and same-edge results
        do_reset();
        b = blog.size();
        push_item(0, 5'd25, 32'h44, 1'b1, 32'h80);
        push_item(1, 5'd7, 32'h77, 1'b0, 32'h0);
        step();
        push_item(2, 5'd8, 32'h88, 1'b0, 32'h0);
        step();
        step();
        chk("t5_valid", 128'(cdb_valid), 128'(1));
        chk("t5_flush", 128'(cdb_take_branch), 128'(1));
        chk("t5_pc", 128'(cdb_target_pc), 128'(32'h80));
        chk("t5_tag", 128'(cdb_tag), 128'(25));
        chk("t5_ready", 128'(src_ready), 128'(3'b111));
        step();
        chk("t5_bubble", 128'(cdb_valid), 128'(0));
        repeat (4) step();
        chk("t5_squashed", 128'(blog.size()), 128'(b + 1));

        // Reset while a broadcast is live and two entries wait
        do_reset();
        push_item(0, 5'd12, 32'hc, 1'b0, 32'h0);
        push_item(1, 5'd13, 32'hd, 1'b0, 32'h0);
        push_item(2, 5'd14, 32'he, 1'b0, 32'h0);
        step(); step(); step();
        chk("t6_live", 128'({cdb_valid, cdb_tag}), 128'({1'b1, 5'd12}));
        reset = 1'b1;
        step();
        chk("t6_rst_out", 128'({cdb_valid, cdb_take_branch, cdb_target_pc, cdb_tag, cdb_value}), 128'(0));
        chk("t6_rst_ready", 128'(src_ready), 128'(0));
        reset = 1'b0;
        step();
        chk("t6_ready", 128'(src_ready), 128'(3'b111));
        b = blog.size();
        repeat (4) step();
        chk("t6_no_stale", 128'(blog.size()), 128'(b));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side producer of the common data bus.
- Collects finished results from the functional units (ALU0, ALU1, MEM) through per-source valid/ready handshakes and buffers them in small per-source FIFOs.
- Broadcasts at most one result per cycle on the CDB, which drives reservation-station wakeup, ROB completion and branch-mispredict flush.
- A broadcast carrying take_branch squashes all buffered results.

Parameters:
- NUM_SRC, 3, number of producing functional units; source index 0 = ALU0, 1 = ALU1, 2 = MEM.
- TAG_W, 5, ROB tag width ($clog2(ROB_SIZE), ROB_SIZE = 32).
- XLEN, 32, result value and PC width.
- BUF_DEPTH, 2, entries per source FIFO; must be ≥ 1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- src_valid  input  NUM_SRC  per-source result valid.
- src_ready  output  NUM_SRC  per-source FIFO can accept.
- src_tag  input  NUM_SRC*TAG_W  ROB tag; source i at [i*TAG_W +: TAG_W].
- src_value  input  NUM_SRC*XLEN  result value, packed the same way.
- src_take_branch  input  NUM_SRC  result is a taken or mispredicted branch.
- src_target_pc  input  NUM_SRC*XLEN  redirect PC, meaningful only when take_branch = 1.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  TAG_W  broadcast ROB tag.
- cdb_value  output  XLEN  broadcast value.
- cdb_take_branch  output  1  broadcast is a flush.
- cdb_target_pc  output  XLEN  redirect PC.

Behaviour:
- Reset: synchronous, active-high. Clock is `clock`, reset is `reset`.
  - All FIFOs empty; rr_ptr = 0.
  - cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_target_pc = 0.
  - src_ready = 0 while reset is high.
  - Reset mid-operation discards all buffered entries and any in-flight broadcast.
- Handshake:
  - A transfer occurs on a rising edge where src_valid[i] && src_ready[i].
  - src_ready[i] = !reset && (count[i] < BUF_DEPTH), derived only from registered state; it does not depend on a same-cycle pop.
  - A source holds valid and payload stable until accepted.
- FIFO: each source has an in-order circular buffer with wrap-around read/write pointers and a count.
  - Push and pop in the same cycle on a non-full FIFO leaves count unchanged.
  - Push when full is impossible because ready is low.
- Arbitration (combinational):
  - Search non-empty FIFOs starting at rr_ptr, ascending modulo NUM_SRC; the first hit is grant g.
  - On a grant: pop the head of FIFO g and set rr_ptr <= (g+1) mod NUM_SRC.
  - No grant: rr_ptr unchanged.
- Output (registered):
  - With a grant: cdb_* <= head of FIFO g, cdb_valid <= 1.
  - Without a grant: cdb_valid <= 0 and the other cdb fields hold their last values.
  - Each broadcast lasts exactly one cycle.
- Latency: a transfer accepted at edge k reaches the CDB at edge k+1 at the earliest (1-cycle minimum; no input-to-CDB bypass).
- Flush: when the granted head has take_branch = 1, at that edge:
  - The flush entry is broadcast normally.
  - All FIFOs are cleared, including pushes accepted on that same edge.
  - rr_ptr <= 0.
  - The next cycle's cdb_valid = 0.
- Tag 0 gets no special treatment; it passes through unchanged.
- Throughput: exactly one broadcast per cycle whenever any FIFO is non-empty; no starvation. A continuously non-empty source waits at most NUM_SRC-1 grants.

Test Plan:
1. Single result:
   - Stimulus: after reset, src0 pushes tag 5, value 0x1234 at edge 1.
   - Required: cdb_valid = 1, tag = 5, value = 0x1234 after edge 2 only; cdb_valid = 0 after edge 3.
2. Simultaneous pushes:
   - Stimulus: sources 0/1/2 push tags 1/2/3 at the same edge, rr_ptr = 0.
   - Required: broadcasts 1, 2, 3 on three consecutive cycles; rr_ptr returns to 0.
3. Fairness:
   - Stimulus: src0 pushes every cycle; src2 pushes tag 9 once.
   - Required: tag 9 broadcast within 2 cycles of its first eligible cycle; src0 tags keep their order.
4. Backpressure and wrap-around:
   - Stimulus: src1 pushes tags 4, 5, 6 back-to-back while src0 is kept busy with higher priority.
   - Required: src1_ready drops after 2 entries; tag 6 is held until ready; order 4, 5, 6 is preserved across pointer wrap.
5. Flush:
   - Stimulus: src0 head carries take_branch = 1, target 0x80; src1 holds tag 7; src2 pushes tag 8 on the flush edge.
   - Required: one broadcast with take_branch = 1 and target_pc = 0x80; tags 7 and 8 are never broadcast; all src_ready = 1 next cycle.
6. Reset mid-operation:
   - Stimulus: assert reset with 2 entries buffered and cdb_valid = 1.
   - Required: next cycle all cdb outputs = 0 and src_ready = 0; after release, src_ready = 1 and no stale broadcast appears.
